// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: opcodes, sequencer states,
// control-word bit positions, microstep encodings and instruction lengths.
package cpu_pkg;

    localparam int unsigned STEP_W = 3;
    localparam int unsigned CTRL_W = 16;

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_LDA = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_STA = 4'b0100,
        OP_LDI = 4'b0101,
        OP_JMP = 4'b0110,
        OP_JC  = 4'b0111,
        OP_JZ  = 4'b1000,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    localparam int unsigned HLT_BIT = 15;
    localparam int unsigned MI_BIT  = 14;
    localparam int unsigned RI_BIT  = 13;
    localparam int unsigned RO_BIT  = 12;
    localparam int unsigned IO_BIT  = 11;
    localparam int unsigned II_BIT  = 10;
    localparam int unsigned AI_BIT  = 9;
    localparam int unsigned AO_BIT  = 8;
    localparam int unsigned EO_BIT  = 7;
    localparam int unsigned SU_BIT  = 6;
    localparam int unsigned BI_BIT  = 5;
    localparam int unsigned OI_BIT  = 4;
    localparam int unsigned CE_BIT  = 3;
    localparam int unsigned CO_BIT  = 2;
    localparam int unsigned J_BIT   = 1;
    localparam int unsigned FI_BIT  = 0;

    localparam logic [CTRL_W-1:0] CTRL_HALT = 16'h8000;

    localparam logic [STEP_W-1:0] STEP_T0 = 3'd0;
    localparam logic [STEP_W-1:0] STEP_T1 = 3'd1;
    localparam logic [STEP_W-1:0] STEP_T2 = 3'd2;
    localparam logic [STEP_W-1:0] STEP_T3 = 3'd3;
    localparam logic [STEP_W-1:0] STEP_T4 = 3'd4;

    // Instruction lengths in cycles, fetch included.
    localparam logic [STEP_W-1:0] LEN_ALU   = 3'd5;
    localparam logic [STEP_W-1:0] LEN_MEM   = 3'd4;
    localparam logic [STEP_W-1:0] LEN_SHORT = 3'd3;

    function automatic logic [STEP_W-1:0] instr_len(input logic [3:0] op);
        logic [STEP_W-1:0] len;
        case (op)
            OP_ADD, OP_SUB: len = LEN_ALU;
            OP_LDA, OP_STA: len = LEN_MEM;
            default:        len = LEN_SHORT;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Signal bundle between the control sequencer and the rest of the datapath.
interface control_sequencer_if;

    logic [3:0]                 opcode;
    logic                       carry;
    logic                       zero;
    logic                       resume;
    logic [cpu_pkg::CTRL_W-1:0] ctrl;
    logic [cpu_pkg::STEP_W-1:0] step;
    logic                       halted;

    modport master (
        output opcode, carry, zero, resume,
        input  ctrl, step, halted
    );

    modport slave (
        input  opcode, carry, zero, resume,
        output ctrl, step, halted
    );

endinterface

// File: rtl/microcode_rom.sv
// Combinational microcode: maps (opcode, microstep, flags) to the control word.
module microcode_rom
    import cpu_pkg::*;
(
    input  logic [3:0]        opcode,
    input  logic [STEP_W-1:0] step,
    input  logic              carry,
    input  logic              zero,
    output logic [CTRL_W-1:0] ctrl
);

    always_comb begin
        ctrl = '0;
        case (step)
            STEP_T0: begin
                ctrl[CO_BIT] = 1'b1;
                ctrl[MI_BIT] = 1'b1;
            end
            STEP_T1: begin
                ctrl[RO_BIT] = 1'b1;
                ctrl[II_BIT] = 1'b1;
                ctrl[CE_BIT] = 1'b1;
            end
            STEP_T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl[IO_BIT] = 1'b1;
                        ctrl[MI_BIT] = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl[IO_BIT] = 1'b1;
                        ctrl[AI_BIT] = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl[IO_BIT] = 1'b1;
                        ctrl[J_BIT]  = 1'b1;
                    end
                    OP_JC: begin
                        ctrl[IO_BIT] = carry;
                        ctrl[J_BIT]  = carry;
                    end
                    OP_JZ: begin
                        ctrl[IO_BIT] = zero;
                        ctrl[J_BIT]  = zero;
                    end
                    OP_OUT: begin
                        ctrl[AO_BIT] = 1'b1;
                        ctrl[OI_BIT] = 1'b1;
                    end
                    OP_HLT: begin
                        ctrl[HLT_BIT] = 1'b1;
                    end
                    default: ;
                endcase
            end
            STEP_T3: begin
                case (opcode)
                    OP_LDA: begin
                        ctrl[RO_BIT] = 1'b1;
                        ctrl[AI_BIT] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl[RO_BIT] = 1'b1;
                        ctrl[BI_BIT] = 1'b1;
                    end
                    OP_STA: begin
                        ctrl[AO_BIT] = 1'b1;
                        ctrl[RI_BIT] = 1'b1;
                    end
                    default: ;
                endcase
            end
            STEP_T4: begin
                case (opcode)
                    OP_ADD, OP_SUB: begin
                        ctrl[EO_BIT] = 1'b1;
                        ctrl[AI_BIT] = 1'b1;
                        ctrl[FI_BIT] = 1'b1;
                        ctrl[SU_BIT] = (opcode == OP_SUB);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Microstep sequencer: RUN/HALTED state, step counter, instruction-length
// termination and the HALTED control-word override around microcode_rom.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    control_sequencer_if.slave  bus
);

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] last_step;
    logic              is_hlt_t2;
    logic              is_last;
    logic [CTRL_W-1:0] rom_ctrl;

    microcode_rom u_rom (
        .opcode (bus.opcode),
        .step   (step_q),
        .carry  (bus.carry),
        .zero   (bus.zero),
        .ctrl   (rom_ctrl)
    );

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        last_step = instr_len(bus.opcode) - 3'd1;
        is_hlt_t2 = (step_q == STEP_T2) && (bus.opcode == OP_HLT);
        // Opcode only shortens an instruction from T2 on; last_step never exceeds T4.
        is_last   = (step_q >= STEP_T2) && (step_q >= last_step);

        case (state_q)
            ST_RUN: begin
                if (is_hlt_t2) begin
                    state_d = ST_HALTED;
                    step_d  = STEP_T0;
                end else if (is_last) begin
                    step_d = STEP_T0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_HALTED: begin
                step_d = STEP_T0;
                if (bus.resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                step_d  = STEP_T0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            step_q  <= STEP_T0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    assign bus.ctrl   = (state_q == ST_HALTED) ? CTRL_HALT : rom_ctrl;
    assign bus.step   = step_q;
    assign bus.halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-instruction control-word
// sequences from a table-driven model, with random opcodes, flags and resume.
module tb_control_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [15:0] exp_w [5];

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    // Whole-instruction view: list of control words, one per cycle.
    task automatic model_seq(input logic [3:0] op, input logic c, input logic z, output int len);
        exp_w[0] = 16'h4004;
        exp_w[1] = 16'h1408;
        exp_w[2] = 16'h0000;
        exp_w[3] = 16'h0000;
        exp_w[4] = 16'h0000;
        len = 3;
        case (op)
            4'h1: begin exp_w[2] = 16'h4800; exp_w[3] = 16'h1200; len = 4; end
            4'h2: begin exp_w[2] = 16'h4800; exp_w[3] = 16'h1020; exp_w[4] = 16'h0281; len = 5; end
            4'h3: begin exp_w[2] = 16'h4800; exp_w[3] = 16'h1020; exp_w[4] = 16'h02C1; len = 5; end
            4'h4: begin exp_w[2] = 16'h4800; exp_w[3] = 16'h2100; len = 4; end
            4'h5: exp_w[2] = 16'h0A00;
            4'h6: exp_w[2] = 16'h0802;
            4'h7: if (c) exp_w[2] = 16'h0802;
            4'h8: if (z) exp_w[2] = 16'h0802;
            4'hE: exp_w[2] = 16'h0110;
            4'hF: exp_w[2] = 16'h8000;
            default: ;
        endcase
    endtask

    // Runs one instruction starting just after the edge that enters T0.
    task automatic run_instr(input logic [3:0] op, input logic c, input logic z,
                             input logic res_at_t2, input int halt_cycles);
        int len;
        model_seq(op, c, z, len);
        for (int s = 0; s < len; s++) begin
            bus.opcode = (s < 2) ? 4'($urandom) : op;
            bus.carry  = (s < 2) ? 1'($urandom) : c;
            bus.zero   = (s < 2) ? 1'($urandom) : z;
            bus.resume = (op == 4'hF && s == 2) ? res_at_t2 : 1'($urandom);
            @(negedge clk);
            vectors++;
            if (bus.ctrl !== exp_w[s] || bus.step !== 3'(s) || bus.halted !== 1'b0) begin
                miscompares++;
                $display("FAIL seq op=%h T%0d: ctrl=%h step=%0d halted=%b, want ctrl=%h step=%0d halted=0",
                         op, s, bus.ctrl, bus.step, bus.halted, exp_w[s], s);
            end
            @(posedge clk); #1;
        end
        bus.resume = 1'b0;
        if (op == 4'hF) begin
            for (int k = 0; k < halt_cycles; k++) begin
                bus.opcode = 4'($urandom);
                bus.carry  = 1'($urandom);
                bus.zero   = 1'($urandom);
                @(negedge clk);
                vectors++;
                if (bus.halted !== 1'b1 || bus.ctrl !== 16'h8000 || bus.step !== 3'd0) begin
                    miscompares++;
                    $display("FAIL halted cycle %0d: halted=%b ctrl=%h step=%0d, want halted=1 ctrl=8000 step=0",
                             k, bus.halted, bus.ctrl, bus.step);
                end
                @(posedge clk); #1;
            end
            bus.resume = 1'b1;
            @(negedge clk);
            vectors++;
            if (bus.halted !== 1'b1 || bus.ctrl !== 16'h8000) begin
                miscompares++;
                $display("FAIL resume cycle: halted=%b ctrl=%h, want halted=1 ctrl=8000", bus.halted, bus.ctrl);
            end
            @(posedge clk); #1;
            bus.resume = 1'b0;
        end
        vectors++;
        if (bus.step !== 3'd0 || bus.ctrl !== 16'h4004 || bus.halted !== 1'b0) begin
            miscompares++;
            $display("FAIL after op=%h: step=%0d ctrl=%h halted=%b, want step=0 ctrl=4004 halted=0",
                     op, bus.step, bus.ctrl, bus.halted);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.opcode = 4'hF;
        bus.carry  = 1'b0;
        bus.zero   = 1'b0;
        bus.resume = 1'b0;
        #2;
        vectors++;
        if (bus.ctrl !== 16'h4004 || bus.step !== 3'd0 || bus.halted !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: ctrl=%h step=%0d halted=%b, want 4004 0 0", bus.ctrl, bus.step, bus.halted);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (bus.ctrl !== 16'h4004 || bus.step !== 3'd0 || bus.halted !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_held: ctrl=%h step=%0d halted=%b, want 4004 0 0", bus.ctrl, bus.step, bus.halted);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        run_instr(4'h2, 1'b0, 1'b0, 1'b0, 0);
        run_instr(4'h3, 1'b1, 1'b1, 1'b0, 0);
        run_instr(4'h1, 1'b0, 1'b1, 1'b0, 0);
        run_instr(4'h4, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_jumps();
        run_instr(4'h7, 1'b0, 1'b1, 1'b0, 0);
        run_instr(4'h7, 1'b1, 1'b0, 1'b0, 0);
        run_instr(4'h8, 1'b0, 1'b1, 1'b0, 0);
        run_instr(4'h8, 1'b1, 1'b0, 1'b0, 0);
        run_instr(4'hA, 1'b1, 1'b1, 1'b0, 0);
        run_instr(4'h6, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_halt();
        run_instr(4'hF, 1'b0, 1'b0, 1'b0, 10);
    endtask

    task automatic test_resume_coincident();
        run_instr(4'hF, 1'b1, 1'b0, 1'b1, 5);
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < 3; s++) begin
            bus.opcode = 4'h3;
            @(posedge clk); #1;
        end
        vectors++;
        if (bus.step !== 3'd3 || bus.ctrl !== 16'h1020) begin
            miscompares++;
            $display("FAIL sub_t3: step=%0d ctrl=%h, want step=3 ctrl=1020", bus.step, bus.ctrl);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (bus.step !== 3'd0 || bus.ctrl !== 16'h4004 || bus.halted !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: step=%0d ctrl=%h halted=%b, want 0 4004 0", bus.step, bus.ctrl, bus.halted);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_instr(4'h3, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_instr(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(1, 4)));
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_jumps();
        test_halt();
        test_resume_coincident();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL: opcode  input  4  instruction register upper nibble; valid from step T2 onward.
REQ-004 SHALL: carry  input  1  registered ALU carry flag.
REQ-005 SHALL: zero  input  1  registered ALU zero flag.
REQ-006 SHALL: resume  input  1  single-cycle pulse; leaves HALTED.
REQ-007 SHALL: ctrl  output  16  control word: [15]HLT [14]MI [13]RI [12]RO [11]IO [10]II [9]AI [8]AO [7]EO [6]SU [5]BI [4]OI [3]CE [2]CO [1]J [0]FI.
REQ-008 SHALL: step  output  3  current microstep, T0..T4 encoded 0..4.
REQ-009 SHALL: halted  output  1  high while in HALTED state.
REQ-010 SHALL: ctrl[6] (SU) drive the ALU subtract input, and ctrl[0] (FI) drive the ALU flags_in input.

Function
REQ-011 SHALL: two states, RUN and HALTED; step counter 3 bits, values 0..4 only.
REQ-012 SHALL: ctrl be a combinational decode of (state, step, opcode, carry, zero); no added latency.
REQ-013 SHALL: fetch steps, all opcodes: T0 = CO|MI (0x4004); T1 = RO|II|CE (0x1408).
REQ-014 SHALL: opcode table, execute steps:
  - 0000 NOP: T2 none.
  - 0001 LDA: T2 IO|MI; T3 RO|AI.
  - 0010 ADD: T2 IO|MI; T3 RO|BI; T4 EO|AI|FI.
  - 0011 SUB: as ADD, plus SU at T4.
  - 0100 STA: T2 IO|MI; T3 AO|RI.
  - 0101 LDI: T2 IO|AI.
  - 0110 JMP: T2 IO|J.
  - 0111 JC: T2 IO|J if carry=1, else none.
  - 1000 JZ: T2 IO|J if zero=1, else none.
  - 1110 OUT: T2 AO|OI.
  - 1111 HLT: T2 HLT.
  - all other opcodes: behave as NOP.
REQ-015 SHALL: instruction length in cycles: ADD/SUB 5; LDA/STA 4; all others, including NOP, undefined and not-taken jumps, 3.
REQ-016 SHALL: in RUN, step advance by 1 each cycle, and return to 0 on the edge ending the instruction's last step; T4 always returns to 0.
REQ-017 SHALL: length decisions use opcode only at T2 or later; T0->T1->T2 is unconditional.
REQ-018 SHALL: on the edge ending HLT T2, state -> HALTED and step -> 0.
REQ-019 SHALL: in HALTED, ctrl = 0x8000 constantly, step held at 0, and halted = 1.
REQ-020 SHALL: resume=1 in HALTED cause state -> RUN on the next edge, with T0 fetch in the following cycle.
REQ-021 SHALL: resume be ignored in RUN, including when coincident with HLT T2; halting takes priority.
REQ-022 SHALL: ctrl never assert bits outside the table entry for the current (opcode, step, flag) combination.

Reset
REQ-023 SHALL: rst=1 immediately force state = RUN, step = 0, halted = 0, so ctrl = 0x4004, independent of clk.
REQ-024 SHALL: reset asserted mid-instruction abandon that instruction; execution restarts at T0 after release.

Structure
REQ-025 SHALL: shared package cpu_pkg hold the opcode enum, the ctrl bit-index constants, the state enum, the per-opcode length constants and the step width.
REQ-026 SHALL: combinational decode live in sub-module microcode_rom (inputs opcode, step, carry, zero; output ctrl word).
REQ-027 SHALL: control_sequencer hold only the state register, the step counter, the length/terminate logic and the halt override.

Verification
REQ-028 SHALL cover: reset, opcode=0010 held -> ctrl 0x4004, 0x1408, 0x4800, 0x1020, 0x0281 over steps 0..4, then step=0.
REQ-029 SHALL cover: opcode=0111: carry=0 -> T2 ctrl 0x0000; carry=1 -> T2 ctrl 0x0802; both cases step=0 next cycle.
REQ-030 SHALL cover: opcode=1000, zero=1 -> T2 ctrl 0x0802; opcode=1010 -> T2 ctrl 0x0000, 3-cycle instruction.
REQ-031 SHALL cover: opcode=1111 -> T2 ctrl 0x8000; halted=1 and ctrl=0x8000 for 10 cycles; resume pulse -> halted=0, ctrl 0x4004 next cycle.
REQ-032 SHALL cover: rst asserted between edges during SUB T3 -> step=0, ctrl 0x4004 before the next clock edge.
REQ-033 SHALL cover: resume coincident with HLT T2 -> halted=1 next cycle and remains 1.
